// File: rtl/cpu_bus_arb_if.sv
// CPU-side memory bus bundle shared by the 6502 core, the OAM DMA engine
// and the debug/loader port. The arbiter takes the slave view; the
// surrounding system (CPU, debug port, memory controller) takes the master view.
interface cpu_bus_arb_if;
    // CPU side
    logic [15:0] cpu_addr;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    // Debug/loader side
    logic        dbg_req;
    logic [15:0] dbg_addr;
    logic        dbg_wr;
    logic [7:0]  dbg_dout;
    logic        dbg_gnt;
    logic [7:0]  dbg_din;
    // Memory controller side
    logic [15:0] mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    // Status
    logic        dma_active;

    modport slave (
        input  cpu_addr, cpu_wr, cpu_dout,
        input  dbg_req, dbg_addr, dbg_wr, dbg_dout,
        input  mem_rdata,
        output cpu_din, cpu_rdy,
        output dbg_gnt, dbg_din,
        output mem_addr, mem_wr, mem_wdata,
        output dma_active
    );

    modport master (
        output cpu_addr, cpu_wr, cpu_dout,
        output dbg_req, dbg_addr, dbg_wr, dbg_dout,
        output mem_rdata,
        input  cpu_din, cpu_rdy,
        input  dbg_gnt, dbg_din,
        input  mem_addr, mem_wr, mem_wdata,
        input  dma_active
    );
endinterface

// File: rtl/cpu_bus_arb.sv
// CPU memory bus arbiter with OAM DMA sequencer.
// Masters: 6502 core (default owner), OAM DMA (triggered by a CPU write to
// DMA_REG_ADDR), debug/loader port (level request).
// Optional build macro CPU_BUS_ARB_DBG_PREEMPT_EN: when defined, a debug
// request raised during DMA is granted at the next byte boundary and DMA
// resumes with the following byte once the debug port lets go.
module cpu_bus_arb #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_bus_arb_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        DMA_START,
        DMA_RD0,
        DMA_RD1,
        DMA_WR,
        DBG
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  lat_q, lat_d;
    logic        dma_resume;

`ifdef CPU_BUS_ARB_DBG_PREEMPT_EN
    logic        resume_q, resume_d;
    assign dma_resume = resume_q;
`else
    assign dma_resume = 1'b0;
`endif

    // Next-state and DMA bookkeeping
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
`ifdef CPU_BUS_ARB_DBG_PREEMPT_EN
        resume_d = resume_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cpu_wr && bus.cpu_addr == DMA_REG_ADDR) begin
                    page_d  = bus.cpu_dout;
                    idx_d   = '0;
                    state_d = DMA_START;
                end else if (bus.dbg_req) begin
                    state_d = DBG;
                end
            end
            DMA_START: state_d = DMA_RD0;
            DMA_RD0:   state_d = DMA_RD1;
            DMA_RD1: begin
                lat_d   = bus.mem_rdata;
                state_d = DMA_WR;
            end
            DMA_WR: begin
                if (idx_q == 8'hFF) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 8'd1;
`ifdef CPU_BUS_ARB_DBG_PREEMPT_EN
                    // idx already points at the next source byte, so the
                    // resume path simply re-enters DMA_RD0.
                    if (bus.dbg_req) begin
                        resume_d = 1'b1;
                        state_d  = DBG;
                    end else begin
                        state_d = DMA_RD0;
                    end
`else
                    state_d = DMA_RD0;
`endif
                end
            end
            DBG: begin
                if (!bus.dbg_req) begin
`ifdef CPU_BUS_ARB_DBG_PREEMPT_EN
                    state_d  = resume_q ? DMA_RD0 : IDLE;
                    resume_d = 1'b0;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and DMA registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            page_q   <= '0;
            idx_q    <= '0;
            lat_q    <= '0;
`ifdef CPU_BUS_ARB_DBG_PREEMPT_EN
            resume_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            lat_q    <= lat_d;
`ifdef CPU_BUS_ARB_DBG_PREEMPT_EN
            resume_q <= resume_d;
`endif
        end
    end

    // Bus mux from the registered state; the debug grant follows dbg_req so
    // it drops in the same cycle the request is withdrawn.
    always_comb begin
        bus.mem_addr   = bus.cpu_addr;
        bus.mem_wr     = 1'b0;
        bus.mem_wdata  = bus.cpu_dout;
        bus.cpu_rdy    = 1'b0;
        bus.dbg_gnt    = 1'b0;
        bus.dma_active = 1'b0;
        case (state_q)
            IDLE: begin
                // Keep the write strobe low while reset is held.
                bus.mem_wr  = bus.cpu_wr & rst_n;
                bus.cpu_rdy = 1'b1;
            end
            DMA_START: begin
                bus.mem_addr   = {page_q, 8'h00};
                bus.mem_wdata  = '0;
                bus.dma_active = 1'b1;
            end
            DMA_RD0, DMA_RD1: begin
                bus.mem_addr   = {page_q, idx_q};
                bus.mem_wdata  = '0;
                bus.dma_active = 1'b1;
            end
            DMA_WR: begin
                bus.mem_addr   = OAM_DATA_ADDR;
                bus.mem_wr     = 1'b1;
                bus.mem_wdata  = lat_q;
                bus.dma_active = 1'b1;
            end
            DBG: begin
                bus.mem_addr   = bus.dbg_addr;
                bus.mem_wdata  = bus.dbg_dout;
                bus.mem_wr     = bus.dbg_wr & bus.dbg_req;
                bus.dbg_gnt    = bus.dbg_req;
                bus.dma_active = dma_resume;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; non-owners ignore it.
    assign bus.cpu_din = bus.mem_rdata;
    assign bus.dbg_din = bus.mem_rdata;

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Directed bench for cpu_bus_arb with a 64 KiB synchronous memory model.
// Checks DMA sequencing, debug grant timing, reset behaviour and, when
// CPU_BUS_ARB_DBG_PREEMPT_EN is defined, debug preemption of DMA.
module tb_cpu_bus_arb;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_bus_arb_if bus ();

    cpu_bus_arb #(
        .DMA_REG_ADDR  (16'h4014),
        .OAM_DATA_ADDR (16'h2004)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Memory model: read data valid the cycle after the address is presented
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Bus monitor (negedge); tests read deltas of these at negedge+1
    logic [7:0]  oam_q [$];
    int          stall_cnt = 0;
    int          dma_cyc   = 0;
    int          lo_hits   = 0;
    int          gnt_dma   = 0;
    logic [15:0] last_src  = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_wr && bus.mem_addr == 16'h2004) oam_q.push_back(bus.mem_wdata);
            if (!bus.cpu_rdy) stall_cnt++;
            if (bus.dma_active) begin
                dma_cyc++;
                if (!bus.mem_wr) begin
                    last_src = bus.mem_addr;
                    if (bus.mem_addr[15:8] == 8'h00) lo_hits++;
                end
            end
            if (bus.dbg_gnt && bus.dma_active) gnt_dma++;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rdy(input string tag);
        for (int k = 0; k < 3000; k++) begin
            sample();
            if (bus.cpu_rdy) break;
        end
        check(tag, bus.cpu_rdy, 1);
    endtask

    task automatic wait_oam(input string tag, input int base, input int n);
        for (int k = 0; k < 3000; k++) begin
            sample();
            if (oam_q.size() - base >= n) break;
        end
        check(tag, oam_q.size() - base, n);
    endtask

    task automatic check_oam(input string tag, input int base);
        int n;
        int bad;
        n   = oam_q.size() - base;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i >= n || oam_q[base + i] !== (8'(i) ^ 8'h5A)) bad++;
        end
        check({tag, "_cnt"}, n, 256);
        check({tag, "_order"}, bad, 0);
    endtask

    task automatic dma_trigger(input logic [7:0] page);
        bus.cpu_addr = 16'h4014;
        bus.cpu_dout = page;
        bus.cpu_wr   = 1'b1;
        step();
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 16'h0000;
    endtask

    task automatic dbg_poke(input logic [15:0] a, input logic [7:0] d);
        bus.dbg_addr = a;
        bus.dbg_dout = d;
        bus.dbg_wr   = 1'b1;
        step();
        bus.dbg_wr   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int st0;
        int n;
        int lo0;
        int dc0;
        int gd0;

        bus.cpu_addr = '0; bus.cpu_wr = 1'b0; bus.cpu_dout = '0;
        bus.dbg_req  = 1'b0; bus.dbg_addr = '0; bus.dbg_wr = 1'b0; bus.dbg_dout = '0;

        // Reset state
        repeat (2) @(posedge clk);
        sample();
        check("rst_cpu_rdy", bus.cpu_rdy, 1);
        check("rst_dbg_gnt", bus.dbg_gnt, 0);
        check("rst_dma_active", bus.dma_active, 0);
        check("rst_mem_wr", bus.mem_wr, 0);
        rst_n = 1'b1;
        step();

        // Preload via the debug port: 0x0200+i = i^5A, 0x0000 = 3C
        bus.dbg_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (bus.dbg_gnt) break;
        end
        check("pre_gnt", bus.dbg_gnt, 1);
        step();
        for (int i = 0; i < 256; i++) dbg_poke(16'h0200 + 16'(i), 8'(i) ^ 8'h5A);
        dbg_poke(16'h0000, 8'h3C);
        bus.dbg_req = 1'b0;
        step();

        // Full DMA from page 0x02
        base = oam_q.size();
        st0  = stall_cnt;
        dma_trigger(8'h02);
        sample();
        check("t2_dma_active", bus.dma_active, 1);
        check("t2_cpu_stall", bus.cpu_rdy, 0);
        wait_rdy("t2_done");
        check("t2_stall_cycles", stall_cnt - st0, 769);
        check_oam("t2_oam", base);

        // Debug write then read back
        step();
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 16'h8000;
        bus.dbg_dout = 8'hA9;
        bus.dbg_wr   = 1'b1;
        sample();
        check("t3_gnt_not_yet", bus.dbg_gnt, 0);
        step();
        sample();
        check("t3_gnt", bus.dbg_gnt, 1);
        check("t3_cpu_stall", bus.cpu_rdy, 0);
        check("t3_mem_addr", bus.mem_addr, 16'h8000);
        check("t3_mem_wr", bus.mem_wr, 1);
        step();
        bus.dbg_wr = 1'b0;
        step();
        sample();
        check("t3_dbg_din", bus.dbg_din, 8'hA9);
        bus.dbg_req = 1'b0;
        bus.dbg_wr  = 1'b1;
        #1;
        check("t3_gnt_drop", bus.dbg_gnt, 0);
        check("t3_wr_drop", bus.mem_wr, 0);
        bus.dbg_wr = 1'b0;
        step();
        sample();
        check("t3_cpu_back", bus.cpu_rdy, 1);

`ifndef CPU_BUS_ARB_DBG_PREEMPT_EN
        // DMA trigger and debug request in the same cycle: DMA first
        step();
        gd0 = gnt_dma;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 16'h9000;
        dma_trigger(8'h03);
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            sample();
            n++;
            if (bus.dbg_gnt) break;
        end
        check("t4_gnt_cycle", n, 771);
        check("t4_gnt_during_dma", gnt_dma - gd0, 0);
        bus.dbg_req = 1'b0;
        step();
        sample();
        check("t4_cpu_back", bus.cpu_rdy, 1);
`else
        // Preempt DMA at byte 10, hold debug for 20 cycles, then resume
        step();
        base = oam_q.size();
        dma_trigger(8'h02);
        wait_oam("t6_reach10", base, 10);
        @(posedge clk);
        #1;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 16'h9000;
        for (int k = 0; k < 20; k++) begin
            sample();
            if (bus.dbg_gnt) break;
        end
        check("t6_gnt", bus.dbg_gnt, 1);
        check("t6_bytes_at_gnt", oam_q.size() - base, 11);
        check("t6_dma_active", bus.dma_active, 1);
        check("t6_cpu_stall", bus.cpu_rdy, 0);
        gd0 = gnt_dma;
        repeat (20) step();
        check("t6_hold_gnt", gnt_dma - gd0, 20);
        bus.dbg_req = 1'b0;
        wait_rdy("t6_done");
        check_oam("t6_oam", base);
`endif

        // DMA from page 0xFF: no wrap into page 0x00
        step();
        base = oam_q.size();
        lo0  = lo_hits;
        dma_trigger(8'hFF);
        wait_rdy("t5_done");
        check("t5_last_src", last_src, 16'hFFFF);
        check("t5_no_low_page", lo_hits - lo0, 0);
        check("t5_oam_cnt", oam_q.size() - base, 256);

        // Debug write to the DMA register does not start DMA
        step();
        dc0 = dma_cyc;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 16'h4014;
        bus.dbg_dout = 8'h05;
        bus.dbg_wr   = 1'b1;
        repeat (3) step();
        bus.dbg_wr  = 1'b0;
        bus.dbg_req = 1'b0;
        repeat (3) step();
        sample();
        check("t5_dbg_no_dma", dma_cyc - dc0, 0);
        check("t5_dma_idle", bus.dma_active, 0);
        check("t5_dbg_wrote", mem[16'h4014], 8'h05);

        // Reset in the middle of DMA byte 100
        step();
        base = oam_q.size();
        dma_trigger(8'h02);
        wait_oam("t1_reach100", base, 100);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_dma_active", bus.dma_active, 0);
        check("t1_cpu_rdy", bus.cpu_rdy, 1);
        check("t1_mem_wr", bus.mem_wr, 0);
        check("t1_dbg_gnt", bus.dbg_gnt, 0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.cpu_addr = 16'h0000;
        bus.cpu_wr   = 1'b0;
        step();
        sample();
        check("t1_cpu_rdy_after", bus.cpu_rdy, 1);
        check("t1_mem_addr", bus.mem_addr, 16'h0000);
        check("t1_cpu_din", bus.cpu_din, 8'h3C);
        repeat (5) step();
        sample();
        check("t1_no_more_oam", oam_q.size() - base, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
